ram_wr_ctrl: RTL and testbench

- Controller sitting in front of the single-port write-capture RAM: ram words N=64, 2^ADDR_BITS=16 words, one write per clock, data_out = last written word.
- After reset it zero-initialises every word, then shares the RAM between two write requesters with round-robin arbitration and a valid/done handshake.
- Optionally read-back verifies each write to detect fault-injected corruption.

---
 rtl/ram_wr_ctrl_pkg.sv | 19 +
 rtl/ram_wr_ctrl_arb.sv | 25 ++
 rtl/ram_wr_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_ram_wr_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/ram_wr_ctrl_pkg.sv
// Shared types and defaults for the RAM write controller (ram_wr_ctrl).
// Optional read-back verification is enabled with the RAM_VERIFY_EN macro.
package ram_wr_ctrl_pkg;

    localparam int N_DEF         = 64;
    localparam int ADDR_BITS_DEF = 4;
    localparam logic [63:0] INIT_VALUE_DEF = 64'd0;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        IDLE  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/ram_wr_ctrl_arb.sv
// Two-way round-robin arbiter: on contention the requester that did not win last time is granted.
module rr_arb2
    import ram_wr_ctrl_pkg::*;
(
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_id
);

    // Pick the winner among the currently valid requesters
    always_comb begin
        grant_valid = valid0 | valid1;
        grant_id    = REQ0;
        if (valid0 && valid1) begin
            grant_id = ~last_grant;
        end else if (valid1) begin
            grant_id = REQ1;
        end else begin
            grant_id = REQ0;
        end
    end

endmodule

// File: rtl/ram_wr_ctrl.sv
// RAM write controller: zero-fills the RAM after reset, then arbitrates two write requesters.
// Define RAM_VERIFY_EN to build the read-back comparator driving err/err_addr.
module ram_wr_ctrl
    import ram_wr_ctrl_pkg::*;
#(
    parameter int N                    = N_DEF,
    parameter int ADDR_BITS            = ADDR_BITS_DEF,
    parameter logic [N-1:0] INIT_VALUE = N'(INIT_VALUE_DEF)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0_valid,
    input  logic [ADDR_BITS-1:0] req0_addr,
    input  logic [N-1:0]         req0_data,
    output logic                 req0_done,
    input  logic                 req1_valid,
    input  logic [ADDR_BITS-1:0] req1_addr,
    input  logic [N-1:0]         req1_data,
    output logic                 req1_done,
    output logic [ADDR_BITS-1:0] ram_addr,
    output logic [N-1:0]         ram_data_in,
    output logic                 ram_wr_en,
    input  logic [N-1:0]         ram_data_out,
    output logic                 init_done,
    output logic                 err,
    output logic [ADDR_BITS-1:0] err_addr
);

    localparam logic [ADDR_BITS-1:0] LAST_ADDR = {ADDR_BITS{1'b1}};

    state_e               state_q, state_d;
    logic [ADDR_BITS-1:0] init_cnt_q, init_cnt_d;
    logic                 last_grant_q, last_grant_d;
    logic                 gnt_id_q, gnt_id_d;
    logic [ADDR_BITS-1:0] ram_addr_q, ram_addr_d;
    logic [N-1:0]         ram_data_in_q, ram_data_in_d;
    logic                 ram_wr_en_q, ram_wr_en_d;
    logic                 req0_done_q, req0_done_d;
    logic                 req1_done_q, req1_done_d;
    logic                 init_done_q, init_done_d;
    logic                 err_q, err_d;
    logic [ADDR_BITS-1:0] err_addr_q, err_addr_d;

    logic arb_valid_s;
    logic arb_id_s;
    logic init_last_s;

    rr_arb2 u_arb (
        .valid0      (req0_valid),
        .valid1      (req1_valid),
        .last_grant  (last_grant_q),
        .grant_valid (arb_valid_s),
        .grant_id    (arb_id_s)
    );

    // The final init word is on the bus once the top address has been issued
    assign init_last_s = ram_wr_en_q && (ram_addr_q == LAST_ADDR);

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= INIT;
            init_cnt_q    <= '0;
            last_grant_q  <= REQ1;
            gnt_id_q      <= REQ0;
            ram_addr_q    <= '0;
            ram_data_in_q <= '0;
            ram_wr_en_q   <= 1'b0;
            req0_done_q   <= 1'b0;
            req1_done_q   <= 1'b0;
            init_done_q   <= 1'b0;
            err_q         <= 1'b0;
            err_addr_q    <= '0;
        end else begin
            state_q       <= state_d;
            init_cnt_q    <= init_cnt_d;
            last_grant_q  <= last_grant_d;
            gnt_id_q      <= gnt_id_d;
            ram_addr_q    <= ram_addr_d;
            ram_data_in_q <= ram_data_in_d;
            ram_wr_en_q   <= ram_wr_en_d;
            req0_done_q   <= req0_done_d;
            req1_done_q   <= req1_done_d;
            init_done_q   <= init_done_d;
            err_q         <= err_d;
            err_addr_q    <= err_addr_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT: begin
                if (init_last_s) state_d = IDLE;
                else             state_d = INIT;
            end
            IDLE: begin
                if (arb_valid_s) state_d = WRITE;
                else             state_d = IDLE;
            end
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = INIT;
        endcase
    end

    // Registered-output and datapath next values
    always_comb begin
        init_cnt_d    = init_cnt_q;
        last_grant_d  = last_grant_q;
        gnt_id_d      = gnt_id_q;
        ram_addr_d    = ram_addr_q;
        ram_data_in_d = ram_data_in_q;
        ram_wr_en_d   = 1'b0;
        req0_done_d   = 1'b0;
        req1_done_d   = 1'b0;
        init_done_d   = init_done_q;
        err_d         = err_q;
        err_addr_d    = err_addr_q;
        case (state_q)
            INIT: begin
                if (init_last_s) begin
                    init_done_d = 1'b1;
                end else begin
                    ram_wr_en_d   = 1'b1;
                    ram_addr_d    = init_cnt_q;
                    ram_data_in_d = INIT_VALUE;
                    if (init_cnt_q != LAST_ADDR) init_cnt_d = init_cnt_q + ADDR_BITS'(1);
                    else                         init_cnt_d = init_cnt_q;
                end
            end
            IDLE: begin
                if (arb_valid_s) begin
                    ram_wr_en_d   = 1'b1;
                    gnt_id_d      = arb_id_s;
                    last_grant_d  = arb_id_s;
                    if (arb_id_s == REQ1) begin
                        ram_addr_d    = req1_addr;
                        ram_data_in_d = req1_data;
                    end else begin
                        ram_addr_d    = req0_addr;
                        ram_data_in_d = req0_data;
                    end
                end else begin
                    ram_wr_en_d = 1'b0;
                end
            end
            WRITE: begin
                req0_done_d = (gnt_id_q == REQ0);
                req1_done_d = (gnt_id_q == REQ1);
            end
            RESP: begin
`ifdef RAM_VERIFY_EN
                // Only the first corrupted address is kept
                if (!err_q && (ram_data_out != ram_data_in_q)) begin
                    err_d      = 1'b1;
                    err_addr_d = ram_addr_q;
                end else begin
                    err_d      = err_q;
                    err_addr_d = err_addr_q;
                end
`else
                err_d      = 1'b0;
                err_addr_d = '0;
`endif
            end
            default: begin
                ram_wr_en_d = 1'b0;
            end
        endcase
    end

`ifndef RAM_VERIFY_EN
    logic unused_rd_s;
    assign unused_rd_s = ^ram_data_out;
`endif

    assign ram_addr    = ram_addr_q;
    assign ram_data_in = ram_data_in_q;
    assign ram_wr_en   = ram_wr_en_q;
    assign req0_done   = req0_done_q;
    assign req1_done   = req1_done_q;
    assign init_done   = init_done_q;
    assign err         = err_q;
    assign err_addr    = err_addr_q;

endmodule

// File: tb/tb_ram_wr_ctrl.sv
// Directed self-checking bench for ram_wr_ctrl with a behavioural write-capture RAM.
module tb_ram_wr_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [3:0]  req0_addr, req1_addr;
    logic [63:0] req0_data, req1_data;
    logic        req0_done, req1_done;
    logic [3:0]  ram_addr;
    logic [63:0] ram_data_in;
    logic        ram_wr_en;
    logic [63:0] ram_data_out = 64'd0;
    logic        init_done;
    logic        err;
    logic [3:0]  err_addr;
    logic        corrupt_en = 1'b0;

    int checks = 0;
    int errors = 0;

`ifdef RAM_VERIFY_EN
    localparam logic       EXP_ERR      = 1'b1;
    localparam logic [3:0] EXP_ERR_ADDR = 4'd9;
`else
    localparam logic       EXP_ERR      = 1'b0;
    localparam logic [3:0] EXP_ERR_ADDR = 4'd0;
`endif

    localparam logic [63:0] D_A   = 64'h1111_2222_3333_4444;
    localparam logic [63:0] D_B   = 64'hAAAA_BBBB_CCCC_DDDD;
    localparam logic [63:0] D_BE  = 64'hDEAD_BEEF_0123_4567;
    localparam logic [63:0] D_INI = 64'h0F0F_0000_FFFF_1234;
    localparam logic [63:0] D_V   = 64'h0000_0000_0000_00F0;

    ram_wr_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0_valid   (req0_valid),
        .req0_addr    (req0_addr),
        .req0_data    (req0_data),
        .req0_done    (req0_done),
        .req1_valid   (req1_valid),
        .req1_addr    (req1_addr),
        .req1_data    (req1_data),
        .req1_done    (req1_done),
        .ram_addr     (ram_addr),
        .ram_data_in  (ram_data_in),
        .ram_wr_en    (ram_wr_en),
        .ram_data_out (ram_data_out),
        .init_done    (init_done),
        .err          (err),
        .err_addr     (err_addr)
    );

    always #5 clk = ~clk;

    // Write-capture RAM: output is the last written word; optional bit-0 fault at address 9
    always @(posedge clk) begin
        if (ram_wr_en) begin
            if (corrupt_en && (ram_addr == 4'd9)) ram_data_out <= ram_data_in ^ 64'd1;
            else                                  ram_data_out <= ram_data_in;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_addr = 4'd0; req0_data = 64'd0;
        req1_valid = 1'b1; req1_addr = 4'd3; req1_data = D_INI;
        tick(); tick();
        chk("rst_wr_en", {63'd0, ram_wr_en}, 64'd0);
        chk("rst_addr", {60'd0, ram_addr}, 64'd0);
        chk("rst_data", ram_data_in, 64'd0);
        chk("rst_init_done", {63'd0, init_done}, 64'd0);
        chk("rst_done", {62'd0, req1_done, req0_done}, 64'd0);
        chk("rst_err", {59'd0, err, err_addr}, 64'd0);

        // Initialisation with req1 held from reset release
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("init_wr_en", {63'd0, ram_wr_en}, 64'd1);
            chk("init_addr", {60'd0, ram_addr}, 64'(i));
            chk("init_data", ram_data_in, 64'd0);
            chk("init_no_done", {62'd0, req1_done, req0_done}, 64'd0);
            chk("init_done_low", {63'd0, init_done}, 64'd0);
        end
        tick();
        chk("init_end_wr_en", {63'd0, ram_wr_en}, 64'd0);
        chk("init_end_done", {63'd0, init_done}, 64'd1);
        tick();
        chk("pend_wr_en", {63'd0, ram_wr_en}, 64'd1);
        chk("pend_addr", {60'd0, ram_addr}, 64'd3);
        chk("pend_data", ram_data_in, D_INI);
        tick();
        chk("pend_done", {62'd0, req1_done, req0_done}, 64'd2);
        chk("pend_rdata", ram_data_out, D_INI);
        chk("pend_resp_wr_en", {63'd0, ram_wr_en}, 64'd0);
        req1_valid = 1'b0;
        tick();
        chk("pend_idle_done", {62'd0, req1_done, req0_done}, 64'd0);
        chk("init_done_held", {63'd0, init_done}, 64'd1);

        // Contention: both held, strict alternation starting with req0
        req0_valid = 1'b1; req0_addr = 4'd1; req0_data = D_A;
        req1_valid = 1'b1; req1_addr = 4'd2; req1_data = D_B;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("cont_wr_en", {63'd0, ram_wr_en}, 64'd1);
            chk("cont_addr", {60'd0, ram_addr}, (k % 2 == 0) ? 64'd1 : 64'd2);
            tick();
            chk("cont_done", {62'd0, req1_done, req0_done}, (k % 2 == 0) ? 64'd1 : 64'd2);
            chk("cont_rdata", ram_data_out, (k % 2 == 0) ? D_A : D_B);
            if (k == 3) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
            tick();
            chk("cont_idle", {61'd0, ram_wr_en, req1_done, req0_done}, 64'd0);
        end

        // Single write from req0
        req0_valid = 1'b1; req0_addr = 4'd5; req0_data = D_BE;
        tick();
        chk("single_wr_en", {63'd0, ram_wr_en}, 64'd1);
        chk("single_addr", {60'd0, ram_addr}, 64'd5);
        chk("single_data", ram_data_in, D_BE);
        tick();
        chk("single_done", {62'd0, req1_done, req0_done}, 64'd1);
        chk("single_rdata", ram_data_out, D_BE);
        req0_valid = 1'b0;
        tick();
        chk("single_idle", {61'd0, ram_wr_en, req1_done, req0_done}, 64'd0);

        // Corrupted write to address 9, then a clean write
        corrupt_en = 1'b1;
        req0_valid = 1'b1; req0_addr = 4'd9; req0_data = D_V;
        tick(); tick();
        chk("vfy_done", {62'd0, req1_done, req0_done}, 64'd1);
        chk("vfy_rdata", ram_data_out, D_V ^ 64'd1);
        req0_valid = 1'b0;
        tick();
        chk("vfy_err", {63'd0, err}, {63'd0, EXP_ERR});
        chk("vfy_err_addr", {60'd0, err_addr}, {60'd0, EXP_ERR_ADDR});
        req1_valid = 1'b1; req1_addr = 4'd4; req1_data = D_A;
        tick(); tick();
        chk("clean_done", {62'd0, req1_done, req0_done}, 64'd2);
        req1_valid = 1'b0;
        tick();
        chk("sticky_err", {63'd0, err}, {63'd0, EXP_ERR});
        chk("sticky_err_addr", {60'd0, err_addr}, {60'd0, EXP_ERR_ADDR});

        // Reset during the WRITE cycle
        req0_valid = 1'b1; req0_addr = 4'd7; req0_data = D_B;
        tick();
        chk("midrst_write", {63'd0, ram_wr_en}, 64'd1);
        rst_n = 1'b0;
        req0_valid = 1'b0;
        tick();
        chk("midrst_no_done", {62'd0, req1_done, req0_done}, 64'd0);
        chk("midrst_addr", {60'd0, ram_addr}, 64'd0);
        chk("midrst_init_done", {63'd0, init_done}, 64'd0);
        chk("midrst_err", {63'd0, err}, 64'd0);
        rst_n = 1'b1;
        tick();
        chk("reinit_wr_en", {63'd0, ram_wr_en}, 64'd1);
        chk("reinit_addr", {60'd0, ram_addr}, 64'd0);
        tick();
        chk("reinit_addr1", {60'd0, ram_addr}, 64'd1);
        chk("reinit_no_done", {62'd0, req1_done, req0_done}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
